// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master: one chip-select-framed word per accepted start, with
// compile-time word width, SCK half-period divider and CPOL/CPHA mode.
//
// state | meaning
// IDLE  | cs high, sck at CPOL, waiting for start
// SETUP | cs low, one half-period before sck edge 1
// SHIFT | sck toggles every HALF_DIV cycles, edges 1..2*DATA_W
// HOLD  | sck back at CPOL, cs held low one half-period before done
module spi_master_cfg #(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 2,
    parameter bit CPOL     = 1'b1,
    parameter bit CPHA     = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam int DIV_W  = $clog2(HALF_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD   = DIV_W'(HALF_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_FINAL = EDGE_W'(2 * DATA_W);

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic                div_tc;
    logic [EDGE_W-1:0]   edge_nxt;
    logic                edge_odd;
    logic                sample_edge;
    logic                drive_edge;

    // edge_nxt is the number of the sck edge registered when div_tc is high
    assign div_tc      = (div_cnt == '0);
    assign edge_nxt    = edge_cnt + 1'b1;
    assign edge_odd    = edge_nxt[0];
    assign sample_edge = CPHA ? ~edge_odd : edge_odd;
    assign drive_edge  = CPHA ? edge_odd : (~edge_odd && (edge_nxt != EDGE_FINAL));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= DIV_LOAD;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            sck      <= CPOL;
            mosi     <= 1'b1;
            cs       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // with CPHA=0 the MSB goes out now, so the register
                        // holds the remaining bits ready for the even edges
                        tx_sr    <= CPHA ? tx_data : {tx_data[DATA_W-2:0], 1'b0};
                        mosi     <= CPHA ? 1'b1 : tx_data[DATA_W-1];
                        rx_sr    <= '0;
                        div_cnt  <= DIV_LOAD;
                        edge_cnt <= '0;
                        sck      <= CPOL;
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP, SHIFT: begin
                    if (div_tc) begin
                        div_cnt  <= DIV_LOAD;
                        edge_cnt <= edge_nxt;
                        sck      <= ~sck;
                        if (sample_edge) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        end
                        if (drive_edge) begin
                            mosi  <= tx_sr[DATA_W-1];
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                        state <= (edge_nxt == EDGE_FINAL) ? HOLD : SHIFT;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (div_tc) begin
                        cs      <= 1'b1;
                        mosi    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Three SPI master configurations checked cycle by cycle against a frame-level
// model (edge count from elapsed cycles), plus directed literal expectations.
module tb_spi_master_cfg;

    localparam int NI = 3;

    function int dw_of(input int i);
        return (i == 2) ? 16 : 8;
    endfunction
    function int hd_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
    endfunction
    function bit cpol_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction
    function bit cpha_of(input int i);
        return (i == 1) ? 1'b1 : 1'b0;
    endfunction

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a [NI];
    logic        start_a [NI];
    logic [15:0] tx_a    [NI];
    logic        cs_a    [NI];
    logic        busy_a  [NI];
    logic        done_a  [NI];
    logic        sck_a   [NI];
    logic        mosi_a  [NI];
    logic        miso_a  [NI];
    logic [15:0] rx_a    [NI];
    logic        lp_f    [NI];
    logic        slv_bit [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DW = dw_of(g);
        logic [DW-1:0] rx_w;
        assign miso_a[g] = lp_f[g] ? mosi_a[g] : slv_bit[g];
        spi_master_cfg #(
            .DATA_W(DW), .HALF_DIV(hd_of(g)), .CPOL(cpol_of(g)), .CPHA(cpha_of(g))
        ) u_dut (
            .clk(clk), .reset(reset_a[g]), .start(start_a[g]), .tx_data(tx_a[g][DW-1:0]),
            .rx_data(rx_w), .busy(busy_a[g]), .done(done_a[g]), .sck(sck_a[g]),
            .mosi(mosi_a[g]), .miso(miso_a[g]), .cs(cs_a[g])
        );
        assign rx_a[g] = 16'(rx_w);
    end

    // frame-level model: active flag, cycles since cs fell, words of the frame
    bit          act     [NI];
    int          n       [NI];
    logic [15:0] txf     [NI];
    logic [15:0] rxf     [NI];
    logic [15:0] last_rx [NI];
    bit          done_e  [NI];
    bit          lp_req  [NI];
    logic [15:0] slv_req [NI];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // predicts the outputs after the coming rising edge from the current inputs
    task automatic model_step();
        int dw, hd;
        logic [15:0] mask;
        for (int i = 0; i < NI; i++) begin
            dw = dw_of(i);
            hd = hd_of(i);
            mask = 16'((32'h1 << dw) - 1);
            if (reset_a[i]) begin
                act[i] = 0; n[i] = 0; done_e[i] = 0; last_rx[i] = '0;
            end else begin
                done_e[i] = 0;
                if (act[i]) begin
                    n[i]++;
                    if (n[i] == (2 * dw + 1) * hd) begin
                        act[i] = 0; done_e[i] = 1; last_rx[i] = rxf[i];
                    end
                end else if (start_a[i]) begin
                    act[i] = 1; n[i] = 0;
                    txf[i] = tx_a[i] & mask;
                    lp_f[i] = lp_req[i];
                    rxf[i] = lp_req[i] ? (tx_a[i] & mask) : (slv_req[i] & mask);
                end
            end
        end
    endtask

    task automatic compare_one(input int i);
        int dw, hd, e, idx, s;
        bit cpol, cpha;
        logic e_sck, e_mosi, e_cs, e_busy;
        dw = dw_of(i); hd = hd_of(i); cpol = cpol_of(i); cpha = cpha_of(i);
        e = 0;
        if (!act[i]) begin
            e_cs = 1'b1; e_busy = 1'b0; e_sck = cpol; e_mosi = 1'b1;
        end else begin
            e = n[i] / hd;
            if (e > 2 * dw) e = 2 * dw;
            e_cs = 1'b0; e_busy = 1'b1;
            e_sck = cpol ^ (e % 2 == 1);
            if (!cpha) begin
                idx = e / 2;
                if (idx > dw - 1) idx = dw - 1;
                e_mosi = txf[i][dw - 1 - idx];
            end else begin
                e_mosi = (e == 0) ? 1'b1 : txf[i][dw - 1 - (e - 1) / 2];
            end
        end
        checks++;
        if (cs_a[i] !== e_cs || busy_a[i] !== e_busy || done_a[i] !== done_e[i] ||
            sck_a[i] !== e_sck || mosi_a[i] !== e_mosi || rx_a[i] !== last_rx[i]) begin
            errors++;
            $display("FAIL cycle %0d inst %0d: got cs=%b busy=%b done=%b sck=%b mosi=%b rx=%h expected cs=%b busy=%b done=%b sck=%b mosi=%b rx=%h",
                     cyc, i, cs_a[i], busy_a[i], done_a[i], sck_a[i], mosi_a[i], rx_a[i],
                     e_cs, e_busy, done_e[i], e_sck, e_mosi, last_rx[i]);
        end
        // slave presents the next bit the master has not yet sampled
        if (act[i]) begin
            s = cpha ? e / 2 : (e + 1) / 2;
            slv_bit[i] = (s < dw) ? rxf[i][dw - 1 - s] : 1'b0;
        end else begin
            slv_bit[i] = 1'($urandom);
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) compare_one(i);
    endtask

    task automatic frame(input int i, input logic [15:0] tx, input logic [15:0] slv,
                         input bit lp, input bit noise, output int lat, output int csl);
        lp_req[i] = lp; slv_req[i] = slv; tx_a[i] = tx; start_a[i] = 1'b1;
        tick();
        start_a[i] = 1'b0;
        tx_a[i] = 16'($urandom);
        lat = 1;
        csl = (cs_a[i] == 1'b0) ? 1 : 0;
        while (!done_a[i] && lat < 400) begin
            if (noise) begin
                start_a[i] = 1'($urandom);
                tx_a[i] = 16'($urandom);
            end
            tick();
            lat++;
            if (cs_a[i] == 1'b0) csl++;
        end
        start_a[i] = 1'b0;
    endtask

    task automatic run_inst(input int i);
        int lat, csl, nd, t, t1, fl;
        fl = (2 * dw_of(i) + 1) * hd_of(i);
        case (i)
            0: begin
                frame(i, 16'h00A5, 16'h0000, 1'b1, 1'b0, lat, csl);
                lit("m0_done_latency", lat, 35);
                lit("m0_cs_low_cycles", csl, 34);
                lit("m0_rx", rx_a[i], 16'h00A5);
            end
            1: begin
                frame(i, 16'h00C3, 16'h003C, 1'b0, 1'b0, lat, csl);
                lit("m3_done_latency", lat, 18);
                lit("m3_rx", rx_a[i], 16'h003C);
            end
            default: begin
                frame(i, 16'hBEEF, 16'h0000, 1'b1, 1'b0, lat, csl);
                lit("w16_done_latency", lat, 100);
                lit("w16_rx", rx_a[i], 16'hBEEF);
            end
        endcase

        lp_req[i] = 1'b1; tx_a[i] = 16'h005A; start_a[i] = 1'b1;
        tick();
        start_a[i] = 1'b0;
        repeat (10) tick();
        start_a[i] = 1'b1; tx_a[i] = 16'h0011;
        tick();
        start_a[i] = 1'b0;
        nd = 0;
        repeat (2 * fl) begin
            tick();
            if (done_a[i]) nd++;
        end
        lit("swb_done_count", nd, 1);
        lit("swb_rx", rx_a[i], 16'h005A);

        lp_req[i] = 1'b1; tx_a[i] = 16'h0001; start_a[i] = 1'b1;
        tick();
        tx_a[i] = 16'h0080;
        t = 1;
        while (!done_a[i] && t < 400) begin tick(); t++; end
        t1 = t;
        lit("b2b_rx_first", rx_a[i], 16'h0001);
        tick(); t++;
        lit("b2b_cs_gap", cs_a[i], 1'b0);
        start_a[i] = 1'b0;
        while (!done_a[i] && t < 800) begin tick(); t++; end
        lit("b2b_done_spacing", t - t1, fl + 1);
        lit("b2b_rx_second", rx_a[i], 16'h0080);

        lp_req[i] = 1'b1; tx_a[i] = 16'($urandom); start_a[i] = 1'b1;
        tick();
        start_a[i] = 1'b0;
        repeat (5 * hd_of(i)) tick();
        reset_a[i] = 1'b1;
        tick();
        lit("rst_cs", cs_a[i], 1'b1);
        lit("rst_sck", sck_a[i], cpol_of(i));
        lit("rst_mosi", mosi_a[i], 1'b1);
        lit("rst_busy", busy_a[i], 1'b0);
        reset_a[i] = 1'b0;
        nd = 0;
        repeat (fl) begin
            tick();
            if (done_a[i]) nd++;
        end
        lit("rst_no_done", nd, 0);
        frame(i, 16'h00FF, 16'h0000, 1'b1, 1'b0, lat, csl);
        lit("rst_then_frame_rx", rx_a[i], 16'h00FF);

        repeat ((i == 2) ? 10 : 25) begin
            repeat ($urandom_range(0, 3)) tick();
            frame(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, lat, csl);
            lit("rnd_done_latency", lat, fl + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            reset_a[i] = 1'b1; start_a[i] = 1'b0; tx_a[i] = '0;
            lp_req[i] = 1'b0; slv_req[i] = '0; lp_f[i] = 1'b0; slv_bit[i] = 1'b0;
            act[i] = 0; n[i] = 0; txf[i] = '0; rxf[i] = '0; last_rx[i] = '0; done_e[i] = 0;
        end
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            lit("reset_cs", cs_a[i], 1'b1);
            lit("reset_busy", busy_a[i], 1'b0);
            lit("reset_sck", sck_a[i], cpol_of(i));
            lit("reset_rx", rx_a[i], 16'h0000);
        end
        for (int i = 0; i < NI; i++) reset_a[i] = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) run_inst(i);
        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
